// File: rtl/uart_lpc_bridge.sv
// uart_lpc_bridge
//
// Turns a byte stream from a UART receiver into LPC host I/O cycles and
// sends the read data plus one status byte back through the UART
// transmitter.
//
// A frame is: command byte, address high, address low, then N data bytes
// for writes only.
// Command byte: bit7 = write, bit4 = auto-increment address,
// bits[BURST_BITS-1:0] = N-1. All other bits are ignored.
// Each read returns one byte and every frame ends with status 0xA5. When
// the watchdog fires, the status byte is 0xEE instead.
//
// Ports
//   clk, reset       single clock, asynchronous active-high reset
//   dataValid/rxData received UART byte strobe and data
//   txReady          UART transmitter idle
//   txSend/txData    one-cycle transmit strobe and byte
//   hostAddr/hostInData/hostIsWrite/hostStart  LPC host request
//   hostIsReady      LPC host can accept a start
//   hostGotResponse/hostOutData                LPC host completion
//   busy             parser is not idle
//   droppedBytes     saturating count of ignored bytes
//
// Optional feature: define LPC_BRIDGE_TIMEOUT_EN to add the response
// watchdog. TIMEOUT_CYCLES sets its limit.

module uart_lpc_bridge #(
    parameter int RESP_DEPTH     = 16,
    parameter int BURST_BITS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataValid,
    input  logic [7:0]  rxData,
    input  logic        txReady,
    output logic        txSend,
    output logic [7:0]  txData,
    output logic [15:0] hostAddr,
    output logic [7:0]  hostInData,
    output logic        hostIsWrite,
    output logic        hostStart,
    input  logic        hostIsReady,
    input  logic        hostGotResponse,
    input  logic [7:0]  hostOutData,
    output logic        busy,
    output logic [7:0]  droppedBytes
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

    typedef enum logic [2:0] {
        IDLE, ADDR_HI, ADDR_LO, WDATA, ISSUE, WAIT, DISCARD, STATUS
    } stateT;

    stateT                 state_q;
    logic                  isWrite_q;
    logic                  autoInc_q;
    logic [BURST_BITS-1:0] cnt_q;
    logic [15:0]           hostAddr_q;
    logic [7:0]            hostInData_q;
    logic                  hostStart_q;
    logic [7:0]            dropped_q;
    logic                  txSend_q;
    logic [7:0]            txData_q;

    logic [7:0]    mem [RESP_DEPTH];
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] count_q;

    logic       pushEn, popEn, roomForTwo, roomForOne, timedOut;
    logic [7:0] pushData;

`ifdef LPC_BRIDGE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wdog_q;
    logic          timedOut_q;
    assign timedOut = timedOut_q;
`else
    logic [31:0] unusedTimeoutCycles;
    assign unusedTimeoutCycles = 32'(TIMEOUT_CYCLES);
    assign timedOut = 1'b0;
`endif

    // A read is only started when its data byte and the closing status
    // byte both still fit, so the FIFO can never overflow.
    assign roomForTwo = (count_q <= DEPTH_C - CW'(2));
    assign roomForOne = (count_q != DEPTH_C);
    assign popEn      = (count_q != '0) && txReady && !txSend_q;

    always_comb begin
        pushEn   = 1'b0;
        pushData = hostOutData;
        if (state_q == WAIT && hostGotResponse && !isWrite_q) begin
            pushEn = 1'b1;
        end else if (state_q == STATUS && roomForOne) begin
            pushEn   = 1'b1;
            pushData = timedOut ? 8'hEE : 8'hA5;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            isWrite_q    <= 1'b0;
            autoInc_q    <= 1'b0;
            cnt_q        <= '0;
            hostAddr_q   <= '0;
            hostInData_q <= '0;
            hostStart_q  <= 1'b0;
            dropped_q    <= '0;
`ifdef LPC_BRIDGE_TIMEOUT_EN
            wdog_q       <= '0;
            timedOut_q   <= 1'b0;
`endif
        end else begin
            hostStart_q <= 1'b0;
`ifdef LPC_BRIDGE_TIMEOUT_EN
            wdog_q <= '0;
`endif
            if (dataValid && (state_q == ISSUE || state_q == WAIT || state_q == STATUS)
                && dropped_q != 8'hFF) begin
                dropped_q <= dropped_q + 8'd1;
            end
            case (state_q)
                IDLE: if (dataValid) begin
                    isWrite_q <= rxData[7];
                    autoInc_q <= rxData[4];
                    cnt_q     <= rxData[BURST_BITS-1:0];
`ifdef LPC_BRIDGE_TIMEOUT_EN
                    timedOut_q <= 1'b0;
`endif
                    state_q   <= ADDR_HI;
                end
                ADDR_HI: if (dataValid) begin
                    hostAddr_q[15:8] <= rxData;
                    state_q          <= ADDR_LO;
                end
                ADDR_LO: if (dataValid) begin
                    hostAddr_q[7:0] <= rxData;
                    state_q         <= isWrite_q ? WDATA : ISSUE;
                end
                WDATA: if (dataValid) begin
                    hostInData_q <= rxData;
                    state_q      <= ISSUE;
                end
                ISSUE: if (hostIsReady && (isWrite_q || roomForTwo)) begin
                    hostStart_q <= 1'b1;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (hostGotResponse) begin
                        if (autoInc_q) hostAddr_q <= hostAddr_q + 16'd1;
                        if (cnt_q == '0) begin
                            state_q <= STATUS;
                        end else begin
                            cnt_q   <= cnt_q - 1'b1;
                            state_q <= isWrite_q ? WDATA : ISSUE;
                        end
                    end
`ifdef LPC_BRIDGE_TIMEOUT_EN
                    else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
                        // cnt_q keeps the number of write bytes still to come
                        timedOut_q <= 1'b1;
                        state_q    <= STATUS;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                STATUS: if (roomForOne) begin
                    state_q <= (timedOut && isWrite_q && cnt_q != '0) ? DISCARD : IDLE;
                end
                DISCARD: if (dataValid) begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == BURST_BITS'(1)) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) mem[wrPtr_q] <= pushData;
    end

    // Transmit drain: one byte per strobe, never two strobes back to back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            txSend_q <= 1'b0;
            txData_q <= '0;
        end else begin
            txSend_q <= popEn;
            if (popEn) begin
                txData_q <= mem[rdPtr_q];
                rdPtr_q  <= rdPtr_q + 1'b1;
            end
            if (pushEn) wrPtr_q <= wrPtr_q + 1'b1;
            case ({pushEn, popEn})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign txSend       = txSend_q;
    assign txData       = txData_q;
    assign hostAddr     = hostAddr_q;
    assign hostInData   = hostInData_q;
    assign hostIsWrite  = isWrite_q;
    assign hostStart    = hostStart_q;
    assign busy         = (state_q != IDLE);
    assign droppedBytes = dropped_q;

endmodule
